// File: rtl/rom_port_arbiter_pkg.sv
// Shared types and constants for the two-master ROM port arbiter.
package rom_port_arbiter_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StData = 1'b1
    } arb_state_e;

    typedef enum logic {
        ArbM0 = 1'b0,
        ArbM1 = 1'b1
    } arb_owner_e;

    localparam int unsigned ArbTimeoutDefault = 16;
    localparam int unsigned RdataW            = 32;

    // Watchdog counter width: wide enough to hold TIMEOUT itself (it saturates there).
    function automatic int unsigned wdog_width(input int unsigned timeout);
        return (timeout > 1) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the ROM slave.
// "master" is the arbiter's view (it masters the ROM bus); "slave" is the environment's view.
interface rom_port_arbiter_if
    import rom_port_arbiter_pkg::*;
#(
    parameter int unsigned AWIDTH = 8
) ();

    logic              m0_req_i;
    logic [AWIDTH-1:0] m0_addr_i;
    logic              m0_gnt_o;
    logic              m0_valid_o;
    logic [RdataW-1:0] m0_rdata_o;
    logic              m0_err_o;

    logic              m1_req_i;
    logic [AWIDTH-1:0] m1_addr_i;
    logic              m1_gnt_o;
    logic              m1_valid_o;
    logic [RdataW-1:0] m1_rdata_o;
    logic              m1_err_o;

    logic              s_hsel_o;
    logic [AWIDTH-1:0] s_haddr_o;
    logic              s_hready_o;
    logic [RdataW-1:0] s_hrdata_i;
    logic              s_hready_i;
    logic              s_hresp_i;

    modport master (
        input  m0_req_i, m0_addr_i, m1_req_i, m1_addr_i,
        input  s_hrdata_i, s_hready_i, s_hresp_i,
        output m0_gnt_o, m0_valid_o, m0_rdata_o, m0_err_o,
        output m1_gnt_o, m1_valid_o, m1_rdata_o, m1_err_o,
        output s_hsel_o, s_haddr_o, s_hready_o
    );

    modport slave (
        output m0_req_i, m0_addr_i, m1_req_i, m1_addr_i,
        output s_hrdata_i, s_hready_i, s_hresp_i,
        input  m0_gnt_o, m0_valid_o, m0_rdata_o, m0_err_o,
        input  m1_gnt_o, m1_valid_o, m1_rdata_o, m1_err_o,
        input  s_hsel_o, s_haddr_o, s_hready_o
    );

endinterface

// File: rtl/rom_port_arbiter_rr_arb2.sv
// Combinational two-way winner select: single requester wins, ties by priority or round-robin.
module rom_port_arbiter_rr_arb2
    import rom_port_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req_i,
    input  arb_owner_e last_i,
    output arb_owner_e winner_o,
    output logic       any_o
);

    always_comb begin
        any_o    = |req_i;
        winner_o = ArbM0;
        case (req_i)
            2'b10:   winner_o = ArbM1;
            2'b11:   winner_o = FIXED_PRIO ? ArbM0 : ((last_i == ArbM0) ? ArbM1 : ArbM0);
            default: winner_o = ArbM0;
        endcase
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Two-master arbiter for a single-ported AHB-style ROM: pipelined address/data phases,
// response routing to the owning master, and a data-phase watchdog.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int unsigned AWIDTH     = 8,
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned TIMEOUT    = ArbTimeoutDefault
) (
    input logic                hclk_i,
    input logic                hreset_n_i,
    rom_port_arbiter_if.master bus
);

    localparam int unsigned      WdogW    = wdog_width(TIMEOUT);
    localparam logic [WdogW-1:0] WdogMax  = WdogW'(TIMEOUT);
    localparam logic [WdogW-1:0] WdogLast = (TIMEOUT > 0) ? WdogW'(TIMEOUT - 1) : '0;
    localparam bit               WdogEn   = (TIMEOUT != 0);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    arb_owner_e        last_q, last_d;
    logic [WdogW-1:0]  wdog_q, wdog_d;
    logic [AWIDTH-1:0] haddr_q, haddr_d;

    arb_owner_e        winner;
    logic              any_req;
    logic              issue_slot;
    logic              grant;
    logic              complete;
    logic              timeout_hit;
    logic              resp_valid;
    logic [RdataW-1:0] resp_rdata;
    logic              resp_err;
    logic [AWIDTH-1:0] win_addr;

    rom_port_arbiter_rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_rr_arb2 (
        .req_i   ({bus.m1_req_i, bus.m0_req_i}),
        .last_i  (last_q),
        .winner_o(winner),
        .any_o   (any_req)
    );

    always_comb begin
        issue_slot  = (state_q == StIdle) || bus.s_hready_i;
        grant       = issue_slot && any_req;
        complete    = (state_q == StData) && bus.s_hready_i;
        timeout_hit = WdogEn && (state_q == StData) && !bus.s_hready_i && (wdog_q == WdogLast);
        resp_valid  = complete || timeout_hit;
        // A forced completion never forwards whatever the stalled slave is driving.
        resp_rdata  = timeout_hit ? '0 : bus.s_hrdata_i;
        resp_err    = timeout_hit || bus.s_hresp_i;
        win_addr    = (winner == ArbM1) ? bus.m1_addr_i : bus.m0_addr_i;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        haddr_d = haddr_q;
        if (grant) begin
            state_d = StData;
            owner_d = winner;
            last_d  = winner;
            wdog_d  = '0;
            haddr_d = win_addr;
        end else if (resp_valid) begin
            state_d = StIdle;
            wdog_d  = '0;
        end else if (state_q == StData) begin
            if (wdog_q != WdogMax) begin
                wdog_d = wdog_q + WdogW'(1);
            end
        end
    end

    always_ff @(posedge hclk_i or negedge hreset_n_i) begin
        if (!hreset_n_i) begin
            state_q <= StIdle;
            owner_q <= ArbM0;
            last_q  <= ArbM1;
            wdog_q  <= '0;
            haddr_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            haddr_q <= haddr_d;
        end
    end

    // Outputs are gated by the reset input so they read 0 the moment reset asserts.
    always_comb begin
        bus.m0_gnt_o   = 1'b0;
        bus.m1_gnt_o   = 1'b0;
        bus.m0_valid_o = 1'b0;
        bus.m1_valid_o = 1'b0;
        bus.m0_rdata_o = '0;
        bus.m1_rdata_o = '0;
        bus.m0_err_o   = 1'b0;
        bus.m1_err_o   = 1'b0;
        bus.s_hsel_o   = 1'b0;
        bus.s_haddr_o  = '0;
        bus.s_hready_o = 1'b0;
        if (hreset_n_i) begin
            bus.s_hsel_o   = grant;
            bus.s_haddr_o  = grant ? win_addr : haddr_q;
            bus.s_hready_o = issue_slot;
            bus.m0_gnt_o   = grant && (winner == ArbM0);
            bus.m1_gnt_o   = grant && (winner == ArbM1);
            bus.m0_valid_o = resp_valid && (owner_q == ArbM0);
            bus.m1_valid_o = resp_valid && (owner_q == ArbM1);
            bus.m0_rdata_o = bus.m0_valid_o ? resp_rdata : '0;
            bus.m1_rdata_o = bus.m1_valid_o ? resp_rdata : '0;
            bus.m0_err_o   = bus.m0_valid_o && resp_err;
            bus.m1_err_o   = bus.m1_valid_o && resp_err;
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: a round-robin and a fixed-priority instance on shared stimulus.
module tb_rom_port_arbiter;
    import rom_port_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       m0_req  = 1'b0;
    logic       m1_req  = 1'b0;
    logic [7:0] m0_addr = 8'h00;
    logic [7:0] m1_addr = 8'h00;
    logic       hready  = 1'b1;
    logic       hresp   = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    rom_port_arbiter_if #(.AWIDTH(8)) ifr ();
    rom_port_arbiter_if #(.AWIDTH(8)) ifp ();

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return 32'hA500_0000 | (32'(a[7:2]) * 32'h0001_0011);
    endfunction

    assign ifr.m0_req_i   = m0_req;
    assign ifr.m0_addr_i  = m0_addr;
    assign ifr.m1_req_i   = m1_req;
    assign ifr.m1_addr_i  = m1_addr;
    assign ifr.s_hready_i = hready;
    assign ifr.s_hresp_i  = hresp;
    assign ifp.m0_req_i   = m0_req;
    assign ifp.m0_addr_i  = m0_addr;
    assign ifp.m1_req_i   = m1_req;
    assign ifp.m1_addr_i  = m1_addr;
    assign ifp.s_hready_i = hready;
    assign ifp.s_hresp_i  = hresp;

    // ROM slave models: latch the address phase, return the word during the data phase.
    logic [7:0] cap_rr, cap_fp;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_rr <= 8'h00;
            cap_fp <= 8'h00;
        end else begin
            if (ifr.s_hsel_o && ifr.s_hready_o) cap_rr <= ifr.s_haddr_o;
            if (ifp.s_hsel_o && ifp.s_hready_o) cap_fp <= ifp.s_haddr_o;
        end
    end
    assign ifr.s_hrdata_i = mem_word(cap_rr);
    assign ifp.s_hrdata_i = mem_word(cap_fp);

    rom_port_arbiter #(.AWIDTH(8), .FIXED_PRIO(1'b0), .TIMEOUT(4)) u_dut_rr (
        .hclk_i    (clk),
        .hreset_n_i(rst_n),
        .bus       (ifr)
    );

    rom_port_arbiter #(.AWIDTH(8), .FIXED_PRIO(1'b1), .TIMEOUT(4)) u_dut_fp (
        .hclk_i    (clk),
        .hreset_n_i(rst_n),
        .bus       (ifp)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] ctrl_rr();
        return {ifr.m0_gnt_o, ifr.m1_gnt_o, ifr.m0_valid_o, ifr.m1_valid_o,
                ifr.s_hsel_o, ifr.s_hready_o};
    endfunction

    function automatic logic [5:0] ctrl_fp();
        return {ifp.m0_gnt_o, ifp.m1_gnt_o, ifp.m0_valid_o, ifp.m1_valid_o,
                ifp.s_hsel_o, ifp.s_hready_o};
    endfunction

    // Scoreboard on the round-robin instance: expected word pushed at grant, popped at VALID.
    typedef struct packed {
        logic        mst;
        logic [31:0] data;
    } sb_t;
    sb_t  sbq[$];
    sb_t  e;
    logic sb_en = 1'b1;

    always @(negedge clk) begin
        if (sb_en) begin
            if (ifr.m0_valid_o || ifr.m1_valid_o) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected_valid", {ifr.m1_valid_o, ifr.m0_valid_o}, 2'b00);
                end else begin
                    e = sbq.pop_front();
                    check("sb_owner", {ifr.m1_valid_o, ifr.m0_valid_o}, e.mst ? 2'b10 : 2'b01);
                    check("sb_rdata", ifr.m1_valid_o ? ifr.m1_rdata_o : ifr.m0_rdata_o, e.data);
                    check("sb_err", ifr.m0_err_o | ifr.m1_err_o, hresp);
                end
            end
            if (ifr.m0_gnt_o) sbq.push_back('{mst: 1'b0, data: mem_word(m0_addr)});
            if (ifr.m1_gnt_o) sbq.push_back('{mst: 1'b1, data: mem_word(m1_addr)});
        end
    end

    task automatic drive(input logic r0, input logic [7:0] a0, input logic r1,
                         input logic [7:0] a1, input logic rdy);
        m0_req  = r0;
        m0_addr = a0;
        m1_req  = r1;
        m1_addr = a1;
        hready  = rdy;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       r0;
        logic [7:0] a0;
        logic       r1;
        logic [7:0] a1;
        logic       rdy;
        logic [5:0] exp;  // {gnt0, gnt1, valid0, valid1, hsel, hready_o}
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 6'b100011};
        tbl[1] = '{1'b1, 8'h08, 1'b1, 8'h10, 1'b1, 6'b011011};
        tbl[2] = '{1'b1, 8'h0C, 1'b1, 8'h14, 1'b1, 6'b100111};
        tbl[3] = '{1'b1, 8'h0C, 1'b1, 8'h14, 1'b0, 6'b000000};
        tbl[4] = '{1'b1, 8'h0C, 1'b1, 8'h18, 1'b1, 6'b011011};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 6'b000101};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 8'h1C, 1'b0, 6'b010011};
        tbl[7] = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b1, 6'b100111};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 6'b001001};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 6'b000001};

        // Reset: outputs forced low even with requests present.
        drive(1'b1, 8'h04, 1'b1, 8'h08, 1'b1);
        #2;
        check("reset_ctrl_rr", {ctrl_rr(), ifr.m0_err_o, ifr.m1_err_o, ifr.s_haddr_o}, 0);
        check("reset_rdata_rr", {ifr.m0_rdata_o, ifr.m1_rdata_o}, 0);
        check("reset_ctrl_fp", {ctrl_fp(), ifp.m0_err_o, ifp.m1_err_o, ifp.s_haddr_o}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Both masters continuously: round-robin alternates from M0, fixed priority keeps M0.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 8'h20 + 8'(4 * k), 1'b1, 8'h40 + 8'(4 * k), 1'b1);
            @(negedge clk);
            check($sformatf("rr_alt%0d", k), {ifr.m0_gnt_o, ifr.m1_gnt_o},
                  (k % 2 == 0) ? 2'b10 : 2'b01);
            check($sformatf("fp_prio%0d", k), {ifp.m0_gnt_o, ifp.m1_gnt_o}, 2'b10);
            advance();
        end
        drive(1'b0, 8'h00, 1'b1, 8'h60, 1'b1);
        @(negedge clk);
        check("fp_m1_when_m0_drops", {ifp.m0_gnt_o, ifp.m1_gnt_o}, 2'b01);
        check("rr_m1_only", {ifr.m0_gnt_o, ifr.m1_gnt_o}, 2'b01);
        advance();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (2) advance();

        // M0 alone at 0x04 every cycle, zero wait states.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'h04, 1'b0, 8'h00, 1'b1);
            @(negedge clk);
            check("t1_gnt", {ifr.m0_gnt_o, ifr.m1_gnt_o, ifr.m1_valid_o}, 3'b100);
            if (k > 0) check("t1_valid0", {ifr.m0_valid_o, ifr.m0_rdata_o},
                             {1'b1, mem_word(8'h04)});
            advance();
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        advance();

        // Vector table from a fresh reset (first tie goes to M0).
        rst_n = 1'b0;
        sbq.delete();
        advance();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].r0, tbl[i].a0, tbl[i].r1, tbl[i].a1, tbl[i].rdy);
            @(negedge clk);
            check($sformatf("vec%0d", i), ctrl_rr(), tbl[i].exp);
            advance();
        end

        // Three wait states on an M1 read while M0 waits for its turn.
        drive(1'b0, 8'h00, 1'b1, 8'h24, 1'b1);
        @(negedge clk);
        check("ws_gnt1", {ifr.m0_gnt_o, ifr.m1_gnt_o}, 2'b01);
        advance();
        for (int w = 0; w < 3; w++) begin
            drive(1'b1, 8'h28, 1'b0, 8'h00, 1'b0);
            @(negedge clk);
            check($sformatf("ws_stall%0d", w),
                  {ifr.m0_gnt_o, ifr.m0_valid_o, ifr.m1_valid_o, ifr.s_hready_o}, 4'b0000);
            advance();
        end
        drive(1'b1, 8'h28, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("ws_release", {ifr.m0_gnt_o, ifr.m1_gnt_o, ifr.m0_valid_o, ifr.m1_valid_o},
              4'b1001);
        advance();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("ws_valid0", {ifr.m0_valid_o, ifr.m1_valid_o}, 2'b10);
        check("haddr_hold", {ifr.s_hsel_o, ifr.s_haddr_o}, {1'b0, 8'h28});
        advance();

        // Slave error response, then a clean transfer.
        drive(1'b1, 8'h0C, 1'b0, 8'h00, 1'b1);
        advance();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        hresp = 1'b1;
        @(negedge clk);
        check("hresp_err", {ifr.m0_valid_o, ifr.m0_err_o, ifr.m1_valid_o, ifr.m1_err_o},
              4'b1100);
        advance();
        hresp = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 8'h14, 1'b1);
        advance();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("after_err", {ifr.m1_valid_o, ifr.m1_err_o, ifr.m1_rdata_o},
              {2'b10, mem_word(8'h14)});
        advance();

        // Watchdog: HREADY held low, forced error on the 4th stall cycle.
        sb_en = 1'b0;
        sbq.delete();
        drive(1'b1, 8'h18, 1'b0, 8'h00, 1'b1);
        advance();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int s = 1; s <= 4; s++) begin
            @(negedge clk);
            if (s < 4) begin
                check($sformatf("wdog_stall%0d", s), {ifr.m0_valid_o, ifr.m1_valid_o}, 2'b00);
            end else begin
                check("wdog_fire_rr", {ifr.m0_valid_o, ifr.m0_err_o, ifr.m0_rdata_o},
                      {2'b11, 32'h0});
                check("wdog_fire_fp", {ifp.m0_valid_o, ifp.m0_err_o, ifp.m0_rdata_o},
                      {2'b11, 32'h0});
            end
            advance();
        end
        @(negedge clk);
        check("wdog_after", {ifr.m0_valid_o, ifr.m1_valid_o}, 2'b00);
        advance();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("wdog_late_hready", {ifr.m0_valid_o, ifr.m1_valid_o, ifr.m0_err_o}, 3'b000);
        advance();
        sb_en = 1'b1;

        // Reset in the middle of a stalled data phase.
        drive(1'b1, 8'h1C, 1'b0, 8'h00, 1'b1);
        advance();
        drive(1'b1, 8'h1C, 1'b1, 8'h2C, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("midreset_rr", {ctrl_rr(), ifr.m0_err_o, ifr.m1_err_o, ifr.s_haddr_o}, 0);
        check("midreset_rdata", {ifr.m0_rdata_o, ifr.m1_rdata_o}, 0);
        check("midreset_fp", {ctrl_fp(), ifp.m0_err_o, ifp.m1_err_o, ifp.s_haddr_o}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8'h30, 1'b1, 8'h34, 1'b1);
        @(negedge clk);
        check("postreset_rr", {ifr.m0_gnt_o, ifr.m1_gnt_o, ifr.m0_valid_o, ifr.m1_valid_o},
              4'b1000);
        check("postreset_fp", {ifp.m0_gnt_o, ifp.m1_gnt_o, ifp.m0_valid_o, ifp.m1_valid_o},
              4'b1000);
        advance();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("postreset_valid0", {ifr.m0_valid_o, ifr.m0_rdata_o}, {1'b1, mem_word(8'h30)});
        advance();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
